led_pattern_engine: RTL and testbench
=====================================

Name: led_pattern_engine

Overview:
Parametrised successor to the fixed-pattern LED mode drivers. It drives N_LED outputs from one selectable pattern engine: OFF, ON, CHASE (running light) and BREATHE (triangular PWM heartbeat). Mode changes are synchronised to PWM frame boundaries so the outputs never glitch. It sits between the mode-select/button logic and the board LED pins, clocked from the 12 MHz board clock.

Parameters:
N_LED, 8, number of LED channels (2..32)
TICK_DIV, 47, prescaler divide ratio; one PWM tick every TICK_DIV clk cycles (>=1)
PWM_BITS, 8, PWM counter and duty width; frame = 2^PWM_BITS ticks
STEP_FRAMES, 4, frames per pattern step (chase shift / duty increment) (>=1)

Ports:
clk  in  1  system clock, 12 MHz
rst  in  1  synchronous reset, active-high
mode_i  in  2  requested mode: 0 OFF, 1 ON, 2 CHASE, 3 BREATHE
mode_load  in  1  one-cycle strobe; captures mode_i as the pending mode
dir_i  in  1  chase direction: 0 = toward MSB, 1 = toward LSB
led_out  out  N_LED  LED drive, 1 = lit, registered
frame_o  out  1  one-cycle pulse on the clk after the PWM counter wraps to 0
mode_o  out  2  currently active mode

Behaviour:
- Reset (sync, rst=1 at a clk edge) clears everything: prescaler=0, pwm_cnt=0, step_cnt=0, duty=0, ramp=up, pos=0, pending valid=0, active mode=OFF, led_out=0, frame_o=0, mode_o=0. Reset mid-pattern takes effect at that edge. No partial state survives.
- Prescaler: counts 0..TICK_DIV-1. tick=1 in the cycle it equals TICK_DIV-1, then it wraps to 0. With TICK_DIV=1, tick is high every cycle.
- pwm_cnt (PWM_BITS wide) increments on tick and wraps modulo 2^PWM_BITS. frame_evt = tick while pwm_cnt is all-ones. frame_o is frame_evt registered, so it has 1-cycle latency.
- step_cnt counts frame_evt 0..STEP_FRAMES-1. step_evt = frame_evt while step_cnt = STEP_FRAMES-1.
- Mode handshake: mode_load latches mode_i into pending and sets pending valid. If several loads arrive before a frame, the last one wins. On frame_evt with pending valid: active mode := pending, pending valid := 0, step_cnt := 0, duty := 0, ramp := up, pos := 0. A mode_load in the same cycle as frame_evt is applied at that same edge. Loading the already-active mode still restarts the pattern state.
- OFF: led_out = 0.
- ON: led_out = all ones.
- CHASE: led_out = one-hot at bit pos. On step_evt, pos moves by one in direction dir_i, sampled at the step. The pattern wraps: N_LED-1 -> 0 when moving toward MSB, 0 -> N_LED-1 when moving toward LSB.
- BREATHE: every bit of led_out = (pwm_cnt < duty). duty=0 gives fully dark; duty=2^PWM_BITS-1 gives lit 2^PWM_BITS-1 of every 2^PWM_BITS ticks.
  - On step_evt with ramp up: duty += 1. If duty is already at max, ramp := down and duty := max-1.
  - On step_evt with ramp down: duty -= 1. If duty is already 0, ramp := up and duty := 1.
  - Each endpoint therefore lasts exactly one step, and there is no overflow.
- Output latency: led_out is registered from the current-cycle counters and state, one clk after the pwm_cnt/pos/duty update.
- Outside BREATHE and CHASE, step_cnt still runs; duty and pos stay frozen at their cleared values.

Decomposition:
- Shared package led_pkg holds:
  - mode constants MODE_OFF=2'd0, MODE_ON=2'd1, MODE_CHASE=2'd2, MODE_BREATHE=2'd3;
  - direction constants DIR_UP=1'b0, DIR_DN=1'b1.
- One sub-module, led_tick_gen: parameter TICK_DIV; ports clk, rst, tick. It is reused by future LED and buzzer blocks.
- The PWM counter, step counter, mode handshake and pattern logic stay in led_pattern_engine.

Test Plan:
Parameters for all scenarios: N_LED=4, TICK_DIV=2, PWM_BITS=3, STEP_FRAMES=1, so frame = 16 clk.
1. Reset and OFF: hold rst 3 cycles then release -> led_out=4'b0000, mode_o=0; first frame_o pulse on clk 16 after release, then every 16 clk.
2. Deferred mode change: mode_load with mode_i=1 at clk 5 -> mode_o stays 0 until the frame_evt edge (clk 15), then becomes 1 and led_out=4'b1111 one clk later. Two loads (2 then 1) inside one frame -> mode 1 becomes active.
3. CHASE wrap: mode 2, dir_i=0 -> led_out over successive steps is 0001, 0010, 0100, 1000, 0001. Switch dir_i=1 mid-run -> 1000 → 0100 → 0010 → 0001 → 1000.
4. BREATHE ramp: mode 3 -> lit ticks per frame go 0,1,…,7,6,…,0,1. Frame with duty=7 shows 7 lit ticks of 8 and 1 dark. Peak and trough each last exactly one frame.
5. Simultaneous load and frame: mode_load with mode_i=3 in the exact cycle of frame_evt while in CHASE -> mode_o=3 at the next edge and duty=0 (all dark for the next frame).
6. Reset mid-BREATHE: assert rst for one cycle at duty=5 -> next edge led_out=0, mode_o=0, and the frame_o period restarts from the release.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants for the LED pattern engines.
//   MODE_*  : pattern selector encoding carried on mode_i / mode_o
//   DIR_*   : chase direction encoding carried on dir_i
//   RAMP_*  : breathe ramp direction held inside the engine
package led_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_CHASE   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam logic RAMP_UP = 1'b0;
  localparam logic RAMP_DN = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: emits a one-cycle tick every TICK_DIV clk cycles.
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   tick : high in the cycle the prescaler sits at TICK_DIV-1 (every cycle when TICK_DIV=1)
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 47
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count 0..TICK_DIV-1, tick on the last value and wrap.
  always_comb begin
    cnt_d = cnt_q;
    tick  = (cnt_q == CNT_LAST);
    if (tick) cnt_d = '0;
    else      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: OFF / ON / CHASE / BREATHE driven from one PWM timebase,
// with mode changes deferred to PWM frame boundaries.
//   clk       : system clock (12 MHz)
//   rst       : synchronous reset, active-high
//   mode_i    : requested mode (MODE_*)
//   mode_load : one-cycle strobe capturing mode_i as the pending mode
//   dir_i     : chase direction (DIR_UP toward MSB, DIR_DN toward LSB)
//   led_out   : registered LED drive, 1 = lit
//   frame_o   : one-cycle pulse after the PWM counter wraps
//   mode_o    : currently active mode
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int unsigned N_LED       = 8,
  parameter int unsigned TICK_DIV    = 47,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_i,
  input  logic             mode_load,
  input  logic             dir_i,
  output logic [N_LED-1:0] led_out,
  output logic             frame_o,
  output logic [1:0]       mode_o
);

  localparam int unsigned POS_W  = $clog2(N_LED);
  localparam int unsigned STEP_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(N_LED - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_FRAMES - 1);

  logic tick;
  logic frame_evt, step_evt;
  logic [1:0] pend_eff;
  logic       pend_vld_eff;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                ramp_q, ramp_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [1:0]          pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [1:0]          mode_q, mode_d;
  logic [N_LED-1:0]    led_q, led_d;
  logic                frame_q, frame_d;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Timebase, mode handshake and pattern stepping.
  always_comb begin
    pwm_cnt_d  = pwm_cnt_q;
    step_cnt_d = step_cnt_q;
    duty_d     = duty_q;
    ramp_d     = ramp_q;
    pos_d      = pos_q;
    mode_d     = mode_q;

    frame_evt = tick && (pwm_cnt_q == DUTY_MAX);
    step_evt  = frame_evt && (step_cnt_q == STEP_LAST);

    if (tick) pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

    // A load in the frame_evt cycle must take effect at that same edge.
    pend_eff     = mode_load ? mode_i : pend_q;
    pend_vld_eff = mode_load | pend_vld_q;
    pend_d       = pend_eff;
    pend_vld_d   = pend_vld_eff;

    if (frame_evt && pend_vld_eff) begin
      mode_d     = pend_eff;
      pend_vld_d = 1'b0;
      step_cnt_d = '0;
      duty_d     = '0;
      ramp_d     = RAMP_UP;
      pos_d      = '0;
    end else begin
      if (frame_evt) begin
        if (step_evt) step_cnt_d = '0;
        else          step_cnt_d = step_cnt_q + STEP_W'(1);
      end
      if (step_evt) begin
        case (mode_q)
          MODE_CHASE: begin
            if (dir_i == DIR_UP) pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
            else                 pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
          end
          MODE_BREATHE: begin
            // Endpoints bounce immediately so each extreme lasts exactly one step.
            if (ramp_q == RAMP_UP) begin
              if (duty_q == DUTY_MAX) begin
                ramp_d = RAMP_DN;
                duty_d = DUTY_MAX - PWM_BITS'(1);
              end else begin
                duty_d = duty_q + PWM_BITS'(1);
              end
            end else begin
              if (duty_q == '0) begin
                ramp_d = RAMP_UP;
                duty_d = PWM_BITS'(1);
              end else begin
                duty_d = duty_q - PWM_BITS'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // LED drive from the current-cycle state; registered below.
  always_comb begin
    led_d   = '0;
    frame_d = frame_evt;
    case (mode_q)
      MODE_ON:      led_d = '1;
      MODE_CHASE:   led_d = N_LED'(1) << pos_q;
      MODE_BREATHE: led_d = {N_LED{pwm_cnt_q < duty_q}};
      default:      led_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      duty_q     <= '0;
      ramp_q     <= RAMP_UP;
      pos_q      <= '0;
      pend_q     <= MODE_OFF;
      pend_vld_q <= 1'b0;
      mode_q     <= MODE_OFF;
      led_q      <= '0;
      frame_q    <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      duty_q     <= duty_d;
      ramp_q     <= ramp_d;
      pos_q      <= pos_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
      frame_q    <= frame_d;
    end
  end

  assign led_out = led_q;
  assign frame_o = frame_q;
  assign mode_o  = mode_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: directed scenarios plus randomized stimulus,
// all outputs compared every cycle against an integer reference model.
module tb_led_pattern_engine;
  import led_pkg::*;

  localparam int N_LED       = 4;
  localparam int TICK_DIV    = 2;
  localparam int PWM_BITS    = 3;
  localparam int STEP_FRAMES = 1;
  localparam int FRAME_TICKS = 1 << PWM_BITS;
  localparam int DMAX        = FRAME_TICKS - 1;
  localparam int ALL_ON      = (1 << N_LED) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       mode_i = 2'd0;
  logic             mode_load = 1'b0;
  logic             dir_i = 1'b0;
  logic [N_LED-1:0] led_out;
  logic             frame_o;
  logic [1:0]       mode_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  led_pattern_engine #(
    .N_LED       (N_LED),
    .TICK_DIV    (TICK_DIV),
    .PWM_BITS    (PWM_BITS),
    .STEP_FRAMES (STEP_FRAMES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_i    (mode_i),
    .mode_load (mode_load),
    .dir_i     (dir_i),
    .led_out   (led_out),
    .frame_o   (frame_o),
    .mode_o    (mode_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (integer counters, per-cycle) ----------------
  int m_presc = 0, m_pwm = 0, m_step = 0, m_duty = 0, m_pos = 0, m_pend = 0, m_mode = 0;
  bit m_up = 1'b1, m_pvld = 1'b0, m_frame = 1'b0;
  int m_led = 0;

  function automatic int model_led(input int md, input int pwm, input int pos, input int duty);
    case (md)
      1:       return ALL_ON;
      2:       return 1 << pos;
      3:       return (pwm < duty) ? ALL_ON : 0;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit tk, fe, se;
    if (rst) begin
      m_presc = 0; m_pwm = 0; m_step = 0; m_duty = 0; m_pos = 0;
      m_pend = 0; m_pvld = 1'b0; m_mode = 0; m_up = 1'b1; m_led = 0; m_frame = 1'b0;
    end else begin
      tk = (m_presc == TICK_DIV - 1);
      fe = tk && (m_pwm == DMAX);
      se = fe && (m_step == STEP_FRAMES - 1);
      m_led   = model_led(m_mode, m_pwm, m_pos, m_duty);
      m_frame = fe;
      m_presc = (m_presc + 1) % TICK_DIV;
      if (tk) m_pwm = (m_pwm + 1) % FRAME_TICKS;
      if (mode_load) begin
        m_pend = int'(mode_i);
        m_pvld = 1'b1;
      end
      if (fe && m_pvld) begin
        m_mode = m_pend; m_pvld = 1'b0;
        m_step = 0; m_duty = 0; m_up = 1'b1; m_pos = 0;
      end else begin
        if (fe) m_step = (m_step + 1) % STEP_FRAMES;
        if (se && m_mode == 2)
          m_pos = dir_i ? (m_pos + N_LED - 1) % N_LED : (m_pos + 1) % N_LED;
        if (se && m_mode == 3) begin
          if (m_up) begin
            if (m_duty == DMAX) begin m_up = 1'b0; m_duty = DMAX - 1; end
            else m_duty = m_duty + 1;
          end else begin
            if (m_duty == 0) begin m_up = 1'b1; m_duty = 1; end
            else m_duty = m_duty - 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check_eq("model_led", 32'(led_out), 32'(m_led));
      check_eq("model_frame", 32'(frame_o), 32'(m_frame));
      check_eq("model_mode", 32'(mode_o), 32'(m_mode));
    end
  end

  // Wait (bounded) for the next frame_o pulse; returns the negedge count taken.
  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame_o && cyc < 64);
    check_eq("frame_seen", 32'(frame_o), 32'd1);
  endtask

  // Lit ticks (in frames) expected for breathe frame k after activation.
  function automatic int breathe_duty(input int k);
    if (k <= DMAX)     return k;
    if (k <= 2 * DMAX) return 2 * DMAX - k;
    return k - 2 * DMAX;
  endfunction

  initial begin
    int cyc;
    int lit;
    logic [N_LED-1:0] exp_led;

    // 1. Reset and OFF
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    check_eq("rst_led", 32'(led_out), 32'd0);
    check_eq("rst_mode", 32'(mode_o), 32'd0);
    check_eq("rst_frame", 32'(frame_o), 32'd0);
    wait_frame(cyc);
    check_eq("first_frame_cyc", 32'(cyc), 32'd16);
    wait_frame(cyc);
    check_eq("frame_period", 32'(cyc), 32'd16);

    // 2. Deferred mode change
    repeat (4) @(negedge clk);
    mode_i = MODE_ON; mode_load = 1'b1;
    @(negedge clk);
    mode_load = 1'b0;
    check_eq("mode_deferred", 32'(mode_o), 32'd0);
    wait_frame(cyc);
    check_eq("mode_on_active", 32'(mode_o), 32'd1);
    @(negedge clk);
    check_eq("on_led", 32'(led_out), 32'hF);
    repeat (3) @(negedge clk);
    mode_i = MODE_ON; mode_load = 1'b1;
    @(negedge clk);
    mode_i = MODE_CHASE;
    @(negedge clk);
    mode_load = 1'b0;
    wait_frame(cyc);
    check_eq("last_load_wins", 32'(mode_o), 32'd2);

    // 3. CHASE wrap both directions
    @(negedge clk);
    check_eq("chase_start", 32'(led_out), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      wait_frame(cyc);
      @(negedge clk);
      exp_led = N_LED'(1 << (i % N_LED));
      check_eq($sformatf("chase_up_%0d", i), 32'(led_out), 32'(exp_led));
    end
    repeat (4) @(negedge clk);
    dir_i = DIR_DN;
    for (int i = 1; i <= 5; i++) begin
      wait_frame(cyc);
      @(negedge clk);
      exp_led = N_LED'(1 << ((N_LED * 4 - i) % N_LED));
      check_eq($sformatf("chase_dn_%0d", i), 32'(led_out), 32'(exp_led));
    end

    // 5. Load coinciding with frame_evt (cycle before frame_o appears)
    repeat (14) @(negedge clk);
    mode_i = MODE_BREATHE; mode_load = 1'b1;
    @(negedge clk);
    mode_load = 1'b0;
    check_eq("sim_frame", 32'(frame_o), 32'd1);
    check_eq("sim_mode", 32'(mode_o), 32'd3);

    // 4. BREATHE ramp: lit clk per frame = TICK_DIV * duty
    for (int k = 0; k < 19; k++) begin
      lit = 0;
      for (int s = 0; s < FRAME_TICKS * TICK_DIV; s++) begin
        @(negedge clk);
        if (k == 0 && s == 0) check_eq("breathe_dark", 32'(led_out), 32'd0);
        lit += int'(led_out[0]);
      end
      check_eq($sformatf("breathe_lit_%0d", k), 32'(lit), 32'(TICK_DIV * breathe_duty(k)));
    end

    // 6. Reset mid-BREATHE (frame 19 has duty 5)
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_led", 32'(led_out), 32'd0);
    check_eq("midrst_mode", 32'(mode_o), 32'd0);
    check_eq("midrst_frame", 32'(frame_o), 32'd0);
    wait_frame(cyc);
    check_eq("midrst_frame_cyc", 32'(cyc), 32'd16);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 299) == 0);
      mode_load = ($urandom_range(0, 5) == 0);
      mode_i    = 2'($urandom);
      if ($urandom_range(0, 19) == 0) dir_i = ~dir_i;
    end
    @(negedge clk);
    rst = 1'b0; mode_load = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
